// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the RAM-side lines of the
// memory port arbiter. The arbiter takes the slave view; the requesters and the
// RAM together take the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) ();

  // Instruction fetch port (read-only)
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;

  // Data load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  // Single-port synchronous RAM
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // Controller status
  logic              busy;

  modport slave (
    input  f_req, f_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  ram_rdata,
    output f_ack, f_rdata,
    output d_ack, d_rdata,
    output ram_addr, ram_wdata, ram_we, ram_re,
    output busy
  );

  modport master (
    output f_req, f_addr,
    output d_req, d_we, d_addr, d_wdata,
    output ram_rdata,
    input  f_ack, f_rdata,
    input  d_ack, d_rdata,
    input  ram_addr, ram_wdata, ram_we, ram_re,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester controller for a single-port synchronous RAM with a one-cycle
// registered read. Every transaction runs IDLE -> ISSUE -> RESP -> DONE, so an
// access granted in cycle 0 acknowledges in cycle 3 and the FSM is back in IDLE
// for cycle 4. Ties alternate between the two ports, starting with data.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input logic              clk,
  input logic              clr_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef enum logic {
    OwnFetch = 1'b0,
    OwnData  = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              grant_data;

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= StIdle;
      owner_q      <= OwnFetch;
      last_owner_q <= OwnFetch;
      store_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      store_q      <= store_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      f_ack_q      <= f_ack_d;
      d_ack_q      <= d_ack_d;
    end
  end

  // Arbitration, transaction sequencing and response capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    store_d      = store_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;

    // Data wins when alone, or on a tie when fetch had the last grant.
    grant_data = bus.d_req && (!bus.f_req || (last_owner_q == OwnFetch));

    case (state_q)
      StIdle: begin
        if (bus.f_req || bus.d_req) begin
          state_d = StIssue;
          if (grant_data) begin
            owner_d      = OwnData;
            last_owner_d = OwnData;
            store_d      = bus.d_we;
            addr_d       = bus.d_addr;
            wdata_d      = bus.d_wdata;
          end else begin
            owner_d      = OwnFetch;
            last_owner_d = OwnFetch;
            store_d      = 1'b0;
            addr_d       = bus.f_addr;
          end
        end
      end
      StIssue: begin
        state_d = StResp;
      end
      StResp: begin
        // RAM output is valid now; capture it so it is stable during DONE.
        state_d = StDone;
        if (owner_q == OwnFetch) begin
          f_rdata_d = bus.ram_rdata;
          f_ack_d   = 1'b1;
        end else begin
          d_ack_d = 1'b1;
          if (!store_q) begin
            d_rdata_d = bus.ram_rdata;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes decode from state so an asynchronous reset drops them at once.
  always_comb begin
    bus.ram_we    = (state_q == StIssue) && store_q;
    bus.ram_re    = (state_q == StIssue) && !store_q;
    bus.ram_addr  = addr_q;
    bus.ram_wdata = wdata_q;
    bus.f_ack     = f_ack_q;
    bus.d_ack     = d_ack_q;
    bus.f_rdata   = f_rdata_q;
    bus.d_rdata   = d_rdata_q;
    bus.busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;

  logic clk;
  logic clr_n;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, write-first not needed: one op per cycle, registered read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drop_reqs();
    bus.f_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    drop_reqs();
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Runs one transaction from a negedge in IDLE; returns the ack latency and
  // what the RAM saw during the cycle after the grant.
  task automatic do_txn(input bit is_d, input bit we, input logic [7:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output int lat,
                        output logic iss_we, output logic iss_re, output logic [7:0] iss_addr,
                        output logic [31:0] iss_wdata, output logic other_ack);
    @(negedge clk);
    if (is_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
    end else begin
      bus.f_req  = 1'b1;
      bus.f_addr = addr;
    end
    lat       = -1;
    rd        = '0;
    other_ack = 1'b0;
    iss_we    = 1'b0;
    iss_re    = 1'b0;
    iss_addr  = '0;
    iss_wdata = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        iss_we    = bus.ram_we;
        iss_re    = bus.ram_re;
        iss_addr  = bus.ram_addr;
        iss_wdata = bus.ram_wdata;
      end
      if (is_d ? bus.f_ack : bus.d_ack) other_ack = 1'b1;
      if (is_d ? bus.d_ack : bus.f_ack) begin
        lat = c;
        rd  = is_d ? bus.d_rdata : bus.f_rdata;
        break;
      end
    end
    drop_reqs();
    @(negedge clk);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        iss_we, iss_re, oack;
    logic [7:0]  iss_addr;
    logic [31:0] iss_wdata;
    logic        seen;
    string       nm;

    checks = 0;
    errors = 0;
    clr_n  = 1'b0;
    drop_reqs();
    bus.f_addr  = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
    mem[0]     <= 32'h0200_0054;
    mem[8'h34] <= 32'h0000_0025;

    //            is_d we  addr   wdata          exp rdata of owner
    vecs[0] = '{1'b1, 1'b1, 8'h52, 32'h0000_002F, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 8'h52, 32'h0,         32'h0000_002F};
    vecs[2] = '{1'b0, 1'b0, 8'h01, 32'h0,         32'hA500_0001};
    vecs[3] = '{1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0000_002F};
    vecs[4] = '{1'b1, 1'b0, 8'h10, 32'h0,         32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 32'h0,         32'hA500_00FF};
    vecs[6] = '{1'b0, 1'b0, 8'hFF, 32'h0,         32'hA500_00FF};
    vecs[7] = '{1'b1, 1'b1, 8'hFF, 32'h1234_5678, 32'hA500_00FF};
    vecs[8] = '{1'b0, 1'b0, 8'hFF, 32'h0,         32'h1234_5678};

    // Outputs held at zero while in reset.
    @(negedge clk);
    @(negedge clk);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_f_ack", bus.f_ack, 1'b0);
    chk1("rst_d_ack", bus.d_ack, 1'b0);
    chk1("rst_ram_we", bus.ram_we, 1'b0);
    chk1("rst_ram_re", bus.ram_re, 1'b0);
    chk("rst_f_rdata", bus.f_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_ram_addr", {24'h0, bus.ram_addr}, 32'h0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
    clr_n = 1'b1;

    // First fetch, cycle by cycle.
    @(negedge clk);
    bus.f_req  = 1'b1;
    bus.f_addr = 8'h00;
    @(negedge clk);
    chk1("f1_c1_ram_re", bus.ram_re, 1'b1);
    chk1("f1_c1_ram_we", bus.ram_we, 1'b0);
    chk1("f1_c1_busy", bus.busy, 1'b1);
    chk1("f1_c1_f_ack", bus.f_ack, 1'b0);
    @(negedge clk);
    chk1("f1_c2_ram_re", bus.ram_re, 1'b0);
    chk1("f1_c2_busy", bus.busy, 1'b1);
    chk1("f1_c2_f_ack", bus.f_ack, 1'b0);
    @(negedge clk);
    chk1("f1_c3_f_ack", bus.f_ack, 1'b1);
    chk1("f1_c3_busy", bus.busy, 1'b1);
    chk1("f1_c3_d_ack", bus.d_ack, 1'b0);
    chk("f1_c3_f_rdata", bus.f_rdata, 32'h0200_0054);
    drop_reqs();
    @(negedge clk);
    chk1("f1_c4_f_ack", bus.f_ack, 1'b0);
    chk1("f1_c4_busy", bus.busy, 1'b0);

    // Table of single transactions.
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat,
             iss_we, iss_re, iss_addr, iss_wdata, oack);
      chk($sformatf("v%0d_latency", i), lat, 32'd3);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk1($sformatf("v%0d_ram_we", i), iss_we, vecs[i].we);
      chk1($sformatf("v%0d_ram_re", i), iss_re, !vecs[i].we);
      chk($sformatf("v%0d_ram_addr", i), {24'h0, iss_addr}, {24'h0, vecs[i].addr});
      if (vecs[i].we) chk($sformatf("v%0d_ram_wdata", i), iss_wdata, vecs[i].wdata);
      chk1($sformatf("v%0d_other_ack", i), oack, 1'b0);
      chk1($sformatf("v%0d_idle_after", i), bus.busy, 1'b0);
    end
    chk("store_keeps_f_rdata", bus.f_rdata, 32'h1234_5678);

    // Address changed after the grant must not affect the access.
    @(negedge clk);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 8'h54;
    @(negedge clk);
    bus.d_addr = 8'h68;
    chk("mid_ram_addr", {24'h0, bus.ram_addr}, 32'h54);
    @(negedge clk);
    @(negedge clk);
    chk1("mid_d_ack", bus.d_ack, 1'b1);
    chk("mid_d_rdata", bus.d_rdata, 32'hA500_0054);
    drop_reqs();
    @(negedge clk);

    // Reset during the write cycle of a store aborts it.
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 8'h34;
    bus.d_wdata = 32'h0000_0099;
    @(negedge clk);
    chk1("abort_pre_ram_we", bus.ram_we, 1'b1);
    #2;
    clr_n = 1'b0;
    #1;
    chk1("abort_ram_we_drop", bus.ram_we, 1'b0);
    chk1("abort_busy_drop", bus.busy, 1'b0);
    drop_reqs();
    seen = 1'b0;
    @(negedge clk);
    if (bus.d_ack) seen = 1'b1;
    clr_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.d_ack) seen = 1'b1;
    end
    chk1("abort_no_d_ack", seen, 1'b0);
    chk1("abort_idle", bus.busy, 1'b0);
    do_txn(1'b1, 1'b0, 8'h34, 32'h0, rd, lat, iss_we, iss_re, iss_addr, iss_wdata, oack);
    chk("abort_old_value", rd, 32'h0000_0025);
    chk("abort_reload_latency", lat, 32'd3);

    // Sustained contention from reset: D, F, D, F with acks 4 cycles apart.
    do_reset();
    @(negedge clk);
    bus.f_req  = 1'b1;
    bus.f_addr = 8'h01;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 8'h02;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      nm = $sformatf("cont_c%0d", c);
      chk1({nm, "_d_ack"}, bus.d_ack, (c == 3) || (c == 11));
      chk1({nm, "_f_ack"}, bus.f_ack, (c == 7) || (c == 15));
      if (c == 3) chk("cont_d_rdata", bus.d_rdata, 32'hA500_0002);
      if (c == 7) chk("cont_f_rdata", bus.f_rdata, 32'hA500_0001);
    end
    drop_reqs();
    @(negedge clk);
    @(negedge clk);
    chk1("cont_idle", bus.busy, 1'b0);

    // Back-to-back fetches at 0, 1, 2.
    @(negedge clk);
    bus.f_req  = 1'b1;
    bus.f_addr = 8'h00;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk1($sformatf("b2b_c%0d_f_ack", c), bus.f_ack, (c == 3) || (c == 7) || (c == 11));
      if (c == 3) begin
        chk("b2b_word0", bus.f_rdata, 32'h0200_0054);
        bus.f_addr = 8'h01;
      end
      if (c == 7) begin
        chk("b2b_word1", bus.f_rdata, 32'hA500_0001);
        bus.f_addr = 8'h02;
      end
      if (c == 11) begin
        chk("b2b_word2", bus.f_rdata, 32'hA500_0002);
        drop_reqs();
      end
    end
    chk1("b2b_idle", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester controller for the CPU's single-port synchronous RAM.
  - Requester 1: instruction fetch, read-only.
  - Requester 2: data load/store.
- Arbitrates between the two, sequences each RAM access (one-cycle registered read latency), and returns data with a one-cycle acknowledge pulse.
- Sits between the control unit's fetch/MDR logic and the RAM. Owns the RAM address, write-enable, read-enable and write-data lines.

Parameters:
ADDR_W, 8, RAM word-address width
DATA_W, 32, data word width

Ports:
clk  in  1  system clock; all state updates on rising edge
clr_n  in  1  asynchronous active-low reset
f_req  in  1  fetch request; held high until f_ack
f_addr  in  ADDR_W  fetch address; stable while f_req high
f_ack  out  1  one-cycle pulse: f_rdata valid
f_rdata  out  DATA_W  fetched word, registered
d_req  in  1  data request; held high until d_ack
d_we  in  1  1 = store, 0 = load; stable while d_req high
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse: load data valid / store done
d_rdata  out  DATA_W  loaded word, registered; unchanged by stores
ram_addr  out  ADDR_W  to RAM address
ram_wdata  out  DATA_W  to RAM data in
ram_we  out  1  to RAM write enable
ram_re  out  1  to RAM read enable
ram_rdata  in  DATA_W  from RAM registered data out
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (clr_n low, asynchronous):
  - State forced to IDLE.
  - All outputs forced to 0: f_ack, d_ack, f_rdata, d_rdata, ram_addr, ram_wdata, ram_we, ram_re, busy.
  - last_owner set to FETCH.
- Reset mid-operation:
  - ram_we/ram_re drop immediately, so a write not yet clocked into the RAM is aborted.
  - No ack is issued for the aborted transaction.
- FSM states: IDLE, ISSUE, RESP, DONE. Every transaction takes exactly 4 cycles, IDLE to IDLE.
- IDLE:
  - If any req is high, arbitrate.
  - Register owner, ram_addr, ram_wdata, and the op (fetch = read).
  - Go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE:
  - Store: ram_we = 1. Load or fetch: ram_re = 1. Exactly one of the two, for exactly this cycle.
  - The RAM performs the op at the closing edge.
  - Go to RESP.
- RESP:
  - ram_we and ram_re are 0.
  - ram_rdata is valid.
  - At the closing edge: for a read, capture ram_rdata into the owner's rdata register; set the owner's ack.
  - Go to DONE.
- DONE:
  - Owner's ack = 1 for this single cycle.
  - Requester must drop req by the next cycle.
  - Go to IDLE with ack cleared.
- Latency: req sampled high in IDLE at cycle 0 → ack high in cycle 3, with rdata valid in that same cycle and held until that port's next read.
- Arbitration:
  - Only one req high → grant it.
  - Both high → grant the port not equal to last_owner.
  - last_owner updates on each grant.
  - First tie after reset goes to DATA.
  - Strict alternation under sustained contention: no starvation, worst-case wait 4 cycles.
- Request change while not in IDLE:
  - Requests are ignored outside IDLE.
  - A newly raised req waits for IDLE.
  - Changing addr, wdata or we after grant has no effect; the values were latched in IDLE.
- Protocol violation: dropping req before ack is a violation. The transaction still completes and ack is still pulsed.
- ram_addr and ram_wdata hold their last values outside ISSUE.
- Address wrap: none. Addresses pass through unmodified, ADDR_W bits.
- Store: d_rdata is not modified.

Test Plan:
- Reset then fetch: RAM preloaded word 0 = 32'h02000054; f_req=1, f_addr=0 at cycle 0 → ram_re=1 only in cycle 1, f_ack=1 only in cycle 3, f_rdata=32'h02000054; busy high in cycles 1-3.
- Store then load: d_we=1, d_addr=8'h52, d_wdata=32'h2F → ram_we=1 for one cycle, d_ack in cycle 3, d_rdata unchanged; then load 8'h52 → d_rdata=32'h0000002F.
- Contention: f_req and d_req both high from reset, held and re-raised after each ack → grant order D, F, D, F; acks 4 cycles apart; no port waits more than 8 cycles.
- Mid-request change: raise d_req (load 8'h54), change d_addr to 8'h68 during ISSUE → data returned is from 8'h54.
- Reset mid-op: assert clr_n=0 during ISSUE of a store to 8'h34 (old value 32'h25) → ram_we drops immediately; no d_ack; after release a load of 8'h34 returns 32'h25; FSM in IDLE.
- Back-to-back fetches: 3 fetches at addresses 0, 1, 2 → acks at cycles 3, 7, 11 with words in address order.
